// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: default geometry and
// helpers for lane indexing and lane-keep mask generation.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 4;
    localparam int MAX_LANES      = 16;

    // Bits needed to index one lane; LANES is a power of two.
    function automatic int lane_idx_width(input int lanes);
        return $clog2(lanes);
    endfunction

    // Mask with the low n bits set; n >= MAX_LANES yields all ones.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_pack_tmr.sv
// Idle timeout counter for the read-side packer. close pulses high when the
// count reaches TIMEOUT-1 and then stays high until the owner clears it.
module fifo_rd_pack_tmr #(
    parameter int TIMEOUT   = 16,
    parameter int TMR_WIDTH = 8
) (
    input  logic r_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic close
);

    localparam logic [TMR_WIDTH-1:0] LAST = TMR_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TMR_WIDTH-1:0] count;
    logic                 held;
    logic                 close_now;

    // Expiry only counts on a genuinely idle cycle; a pop in that cycle wins.
    assign close_now = (TIMEOUT != 0) && en && (count == LAST);
    assign close     = close_now || held;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            held  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            held  <= 1'b0;
        end else if (held) begin
            count <= count;
        end else if (close_now) begin
            held  <= 1'b1;
        end else if (en) begin
            count <= count + TMR_WIDTH'(1);
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/fifo_rd_pack.sv
// Read-domain FIFO consumer: pops DATA_WIDTH entries, packs LANES of them
// into one word and presents it on a valid/ready output with a keep mask.
module fifo_rd_pack
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int TIMEOUT    = 16,
    parameter int TMR_WIDTH  = 8
) (
    input  logic                          r_clk,
    input  logic                          rst_n,
    input  logic                          r_empty,
    input  logic [DATA_WIDTH-1:0]         r_data,
    output logic                          r_pop,
    input  logic                          flush,
    output logic [DATA_WIDTH*LANES-1:0]   o_data,
    output logic [LANES-1:0]              o_keep,
    output logic                          o_valid,
    input  logic                          o_ready
);

    localparam int IW = lane_idx_width(LANES);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(LANES);

    logic [DATA_WIDTH-1:0]       lane_q [LANES];
    logic [CW-1:0]               fill;
    logic                        inflight;
    logic                        flush_pend;
    logic [CW-1:0]               cnt;
    logic                        tmr_close;
    logic                        tmr_en;
    logic                        close;
    logic                        word_ready;
    logic                        load_out;
    logic [DATA_WIDTH*LANES-1:0] asm_word;
    logic [LANES-1:0]            keep_w;

    // cnt counts the entry arriving on r_data this cycle, so a word whose last
    // lane is still in flight loads straight from r_data with no bubble.
    assign cnt        = fill + CW'(inflight);
    assign close      = tmr_close || flush_pend;
    assign word_ready = (cnt == FULL) || (close && (fill != '0) && !inflight);
    assign load_out   = word_ready && (!o_valid || o_ready);
    assign r_pop      = rst_n && !r_empty && !flush_pend && ((cnt < FULL) || load_out);
    assign tmr_en     = (fill != '0) && !inflight && !r_pop;
    assign keep_w     = LANES'(keep_mask(int'(cnt)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        asm_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < fill) begin
                asm_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
            end else if (inflight && (CW'(i) == fill)) begin
                asm_word[i*DATA_WIDTH +: DATA_WIDTH] = r_data;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            fill       <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_keep     <= '0;
        end else begin
            inflight <= r_pop;
            if (load_out) begin
                o_data  <= asm_word;
                o_keep  <= keep_w;
                o_valid <= 1'b1;
                fill    <= '0;
            end else begin
                if (o_valid && o_ready) begin
                    o_valid <= 1'b0;
                end
                if (inflight) begin
                    fill <= fill + CW'(1);
                end
            end

            // A flush landing on a load only survives if data keeps streaming in.
            if (load_out) begin
                flush_pend <= flush && r_pop;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end else if ((fill == '0) && !inflight) begin
                flush_pend <= 1'b0;
            end
        end
    end

    // NOTE: lane storage has no reset; its contents are only ever qualified by fill.
    always_ff @(posedge r_clk) begin
        if (inflight && !load_out) begin
            lane_q[fill[IW-1:0]] <= r_data;
        end
    end

    fifo_rd_pack_tmr #(
        .TIMEOUT   (TIMEOUT),
        .TMR_WIDTH (TMR_WIDTH)
    ) u_tmr (
        .r_clk (r_clk),
        .rst_n (rst_n),
        .clr   (load_out),
        .en    (tmr_en),
        .close (tmr_close)
    );

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Bench for fifo_rd_pack: a queue-based FIFO source and an order-preserving
// scoreboard, directed scenarios with exact words, then randomized traffic.
module tb_fifo_rd_pack;

    localparam int DW        = 8;
    localparam int LANES     = 4;
    localparam int TIMEOUT   = 16;
    localparam int TMR_WIDTH = 8;

    logic                  r_clk   = 1'b0;
    logic                  rst_n   = 1'b0;
    logic                  r_empty = 1'b1;
    logic [DW-1:0]         r_data  = '0;
    logic                  r_pop;
    logic                  flush   = 1'b0;
    logic [DW*LANES-1:0]   o_data;
    logic [LANES-1:0]      o_keep;
    logic                  o_valid;
    logic                  o_ready = 1'b0;

    fifo_rd_pack #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .TIMEOUT    (TIMEOUT),
        .TMR_WIDTH  (TMR_WIDTH)
    ) dut (
        .r_clk   (r_clk),
        .rst_n   (rst_n),
        .r_empty (r_empty),
        .r_data  (r_data),
        .r_pop   (r_pop),
        .flush   (flush),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [DW*LANES-1:0] data;
        logic [LANES-1:0]    keep;
        int                  cyc;
        int                  pops;
    } word_t;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]       fifo_q [$];
    logic [DW-1:0]       exp_q  [$];
    word_t               got_q  [$];
    int                  cyc = 0, pops = 0, first_pop_cyc = 0, last_pop_cyc = 0;
    bit                  src_on = 0, rdy_on = 0, flush_req = 0, pend_v = 0, stall_prev = 0;
    logic [DW-1:0]       pend_d;
    logic [DW*LANES-1:0] prev_data;
    logic [LANES-1:0]    prev_keep;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe on the falling edge.
    task automatic step();
        logic [LANES-1:0] kp1;
        @(posedge r_clk);
        #1;
        if (pend_v) begin
            r_data = pend_d;
            pend_v = 0;
        end
        r_empty   = !(src_on && fifo_q.size() > 0);
        o_ready   = rdy_on;
        flush     = flush_req;
        flush_req = 0;
        @(negedge r_clk);
        cyc++;
        if (stall_prev) begin
            check("stall_valid", o_valid, 1);
            check("stall_data", o_data, prev_data);
            check("stall_keep", o_keep, prev_keep);
        end
        if (o_valid && o_ready) begin
            word_t w;
            w.data = o_data;
            w.keep = o_keep;
            w.cyc  = cyc;
            w.pops = pops;
            got_q.push_back(w);
            kp1 = o_keep + LANES'(1);
            check("keep_shape", ((o_keep & kp1) == '0) && (o_keep != '0), 1);
            for (int i = 0; i < LANES; i++) begin
                if (o_keep[i]) begin
                    if (exp_q.size() == 0) check("lane_extra", 1, 0);
                    else check($sformatf("lane%0d", i), o_data[i*DW +: DW], exp_q.pop_front());
                end else begin
                    check("pad_zero", o_data[i*DW +: DW], 0);
                end
            end
        end
        stall_prev = o_valid && !o_ready;
        prev_data  = o_data;
        prev_keep  = o_keep;
        if (r_pop) begin
            check("pop_nonempty", r_empty, 0);
            if (!r_empty) begin
                pend_d = fifo_q.pop_front();
                pend_v = 1;
                exp_q.push_back(pend_d);
                if (pops == 0) first_pop_cyc = cyc;
                pops++;
                last_pop_cyc = cyc;
                check("held_bound", exp_q.size() <= 2 * LANES, 1);
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_words(input int n, input int budget);
        int b;
        b = budget;
        while (got_q.size() < n && b > 0) begin
            step();
            b--;
        end
        check("word_wait", got_q.size(), n);
    endtask

    task automatic run_pops(input int n, input int budget);
        int b;
        b = budget;
        while (pops < n && b > 0) begin
            step();
            b--;
        end
        check("pop_wait", pops, n);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] d, input logic [3:0] k);
        if (idx < got_q.size()) begin
            check({tag, "_data"}, got_q[idx].data, d);
            check({tag, "_keep"}, got_q[idx].keep, k);
        end else begin
            check({tag, "_missing"}, got_q.size(), idx + 1);
        end
    endtask

    task automatic new_test();
        got_q.delete();
        pops = 0;
    endtask

    initial begin
        int n_before, k3, dens;

        // Reset state while the FIFO claims data.
        r_empty = 1'b0;
        #3;
        check("rst_rpop", r_pop, 0);
        check("rst_valid", o_valid, 0);
        check("rst_keep", o_keep, 0);
        check("rst_data", o_data, 0);
        r_empty = 1'b1;
        #19 rst_n = 1'b1;

        // Streaming: two full words, eight back-to-back pops.
        new_test();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        src_on = 1;
        rdy_on = 1;
        run_words(2, 40);
        check_word("stream0", 0, 32'h04030201, 4'hF);
        check_word("stream1", 1, 32'h08070605, 4'hF);
        check("stream_pops", pops, 8);
        check("stream_run", last_pop_cyc - first_pop_cyc, 7);
        run_cycles(4);

        // Backpressure: only two words' worth is held.
        new_test();
        rdy_on = 0;
        for (int i = 1; i <= 12; i++) fifo_q.push_back(DW'(i));
        run_cycles(20);
        check("bp_pops", pops, 8);
        check("bp_rpop", r_pop, 0);
        check("bp_held", exp_q.size(), 8);
        rdy_on = 1;
        run_words(3, 40);
        check_word("bp0", 0, 32'h04030201, 4'hF);
        check_word("bp1", 1, 32'h08070605, 4'hF);
        check_word("bp2", 2, 32'h0C0B0A09, 4'hF);
        run_cycles(4);

        // Timeout closes a two-entry partial word.
        new_test();
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        run_words(1, 60);
        check_word("tmo", 0, 32'h0000A2A1, 4'h3);
        if (got_q.size() > 0) check("tmo_latency", got_q[0].cyc - last_pop_cyc, TIMEOUT + 2);

        // Flush issued together with the third pop.
        new_test();
        fifo_q.push_back(8'hC1);
        fifo_q.push_back(8'hC2);
        fifo_q.push_back(8'hC3);
        fifo_q.push_back(8'hC4);
        run_pops(2, 20);
        flush_req = 1;
        run_words(1, 30);
        check_word("flush", 0, 32'h00C3C2C1, 4'h7);
        if (got_q.size() > 0) check("flush_no4th", got_q[0].pops, 3);
        run_cycles(5);
        flush_req = 1;
        run_words(2, 30);
        check_word("flush_tail", 1, 32'h000000C4, 4'h1);

        // Flush with nothing assembled produces no word.
        run_cycles(5);
        n_before = got_q.size();
        flush_req = 1;
        run_cycles(10);
        check("flush_empty", got_q.size(), n_before);

        // Fourth entry popped in the very cycle the timer would expire.
        new_test();
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        fifo_q.push_back(8'hB3);
        run_pops(3, 20);
        k3 = last_pop_cyc;
        src_on = 0;
        fifo_q.push_back(8'hB4);
        while (cyc < k3 + TIMEOUT) step();
        src_on = 1;
        run_cycles(40);
        check("bound_words", got_q.size(), 1);
        check_word("bound", 0, 32'hB4B3B2B1, 4'hF);

        // Randomized traffic in dense, medium and sparse phases.
        for (int blk = 0; blk < 15; blk++) begin
            case ($urandom_range(0, 2))
                0:       dens = 90;
                1:       dens = 50;
                default: dens = 5;
            endcase
            for (int c = 0; c < 200; c++) begin
                src_on = ($urandom_range(0, 99) < dens);
                rdy_on = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 99) < 3) flush_req = 1;
                if (fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
                step();
            end
        end
        src_on = 0;
        rdy_on = 1;
        flush_req = 1;
        run_cycles(60);
        check("rand_drain", exp_q.size(), 0);
        fifo_q.delete();

        // Reset asserted mid-stream with a stalled output.
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'($urandom));
        src_on = 1;
        rdy_on = 0;
        run_cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_keep", o_keep, 0);
        check("mid_rst_rpop", r_pop, 0);
        exp_q.delete();
        fifo_q.delete();
        pend_v = 0;
        stall_prev = 0;
        run_cycles(3);
        #2 rst_n = 1'b1;
        new_test();
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h11 + i));
        rdy_on = 1;
        run_words(1, 30);
        check_word("post_rst", 0, 32'h14131211, 4'hF);
        run_cycles(30);
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_pack.md
Name: fifo_rd_pack

Overview:
Read-side consumer of the async byte FIFO, running in the FIFO read clock domain. It pops DATA_WIDTH-bit entries through the FIFO's r_pop/r_empty/r_data interface and packs LANES consecutive entries into one wide word. The wide word is presented on a valid/ready output. A partial word is closed and emitted after an idle timeout or on an explicit flush, with a lane-keep mask marking the valid lanes.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (one lane)
LANES, 4, entries packed per output word; power of two, 2..16
TIMEOUT, 16, idle cycles before a partial word is closed; 0 disables timeout
TMR_WIDTH, 8, timeout counter width; must satisfy TIMEOUT < 2**TMR_WIDTH

Ports:
r_clk  input  1  read-domain clock, rising edge
rst_n  input  1  asynchronous active-low reset
r_empty  input  1  FIFO empty flag
r_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop
r_pop  output  1  FIFO pop request
flush  input  1  single-cycle pulse requesting closure of the current partial word
o_data  output  DATA_WIDTH*LANES  packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest entry
o_keep  output  LANES  valid-lane mask
o_valid  output  1  output word valid
o_ready  input  1  downstream accept

Behaviour:
- Reset (async assert, sync release):
  - o_valid=0, o_data=0, o_keep=0.
  - Fill count=0, in-flight flag=0, timer=0, flush-pending=0.
  - r_pop=0 while rst_n low.
  - Reset mid-word discards the assembly, any in-flight entry and any unaccepted output.
- FIFO read latency is 1:
  - A pop is accepted when r_pop=1 and r_empty=0.
  - inflight<=1 on an accepted pop; the entry is captured from r_data on the next edge into lane[fill], then fill increments.
- r_pop is combinational and is driven only when both hold:
  - r_empty=0;
  - (fill + inflight < LANES) or load_out this cycle.
- r_pop is never asserted while flush-pending=1.
- load_out = word_ready and (o_valid=0 or o_ready=1).
  - word_ready = (fill==LANES) or (close and fill>0 and inflight=0).
  - On load_out: o_data<=assembly, with lanes >= fill forced to 0; o_keep<=(1<<fill)-1, or all-ones when full; o_valid<=1; fill<=0; timer<=0; flush-pending<=0.
- Output handshake:
  - A word transfers on o_valid and o_ready.
  - Once o_valid=1, o_data and o_keep are held stable until the transfer.
  - o_valid drops after the transfer unless a new load_out occurs in the same cycle.
  - Back-to-back words at one per cycle are supported.
- Sustained throughput is one entry per cycle when r_empty=0 and o_ready=1, with no bubble at word boundaries.
- Storage is one assembly register plus one output register. At most 2*LANES entries are held, including the in-flight entry, before popping stops.
- Timeout:
  - The timer increments each cycle with fill>0, inflight=0 and no accepted pop; otherwise it is 0.
  - close is asserted when timer==TIMEOUT-1 (TIMEOUT≠0).
  - close is held until load_out.
- Flush:
  - A flush pulse sets flush-pending; flush-pending forces close.
  - If fill=0 and inflight=0, flush-pending clears next cycle with no output.
  - A flush arriving during inflight waits for the entry's arrival, then closes.
- Simultaneous events:
  - A full word and a timeout in the same cycle emit the full word (keep all-ones).
  - A flush coinciding with load_out of a full word applies to the next partial only if fill>0 afterwards; otherwise it is dropped.

Decomposition:
- Shared package fifo_pkg: LANES/DATA_WIDTH defaults, lane-index width function, keep-mask generation function.
- Sub-module fifo_rd_pack_tmr: idle timeout counter with clear, enable and close outputs. Everything else is flat.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> o_valid=0, o_keep=0, r_pop=0 immediately; after release the first output word starts at lane 0.
- Stream: FIFO holds 0x01..0x08, o_ready=1 -> o_data=0x04030201 then 0x08070605, o_keep=0xF; r_pop high 8 consecutive cycles; r_pop never asserted while r_empty=1.
- Backpressure: o_ready=0, FIFO holds 12 entries -> exactly 8 popped, then r_pop=0. Raise o_ready -> words 0x04030201, 0x08070605, 0x0C0B0A09 in order; o_data stable while stalled.
- Timeout: push 0xA1, 0xA2, then FIFO empty -> exactly TIMEOUT cycles after 0xA2 is captured, o_data=0x0000A2A1, o_keep=0x3.
- Flush with in-flight: flush in the same cycle as the pop of the 3rd entry (0xC1, 0xC2, 0xC3) -> o_data=0x00C3C2C1, o_keep=0x7 after arrival; no 4th pop until the word loads. Flush with fill=0 produces no output.
- Boundary: 4th entry captured in the same cycle the timer would expire -> single word with o_keep=0xF and no extra partial word.
